// File: rtl/clkdiv_pkg.sv
// Shared types, default parameters and the effective-high helper for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned N_CH_DEF  = 4;
    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned MAX_W     = 16;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_t;

    // One extra bit holds div+1 so div = all-ones still halves correctly.
    function automatic logic [MAX_W-1:0] eff_high(
        input logic [MAX_W-1:0] div,
        input logic [MAX_W-1:0] high,
        input logic             half
    );
        logic [MAX_W:0] p;
        p = ({1'b0, div} + (MAX_W+1)'(1)) >> 1;
        return half ? MAX_W'(p) : high;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, shadowed divisor/high length, registered clock and tick outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] high_i,
    input  logic             half_i,
    input  logic             sync_i,
    output logic             clk_out,
    output logic             tick_o
);

    ch_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] high_r;
    logic [MAX_W-1:0] h_ext;
    logic [DIV_W-1:0] h;
    logic             reload;
    logic             out_r;
    logic             tick_r;

    assign h_ext   = eff_high(MAX_W'(div_i), MAX_W'(high_i), half_i);
    assign h       = DIV_W'(h_ext);
    assign cnt_nxt = cnt + DIV_W'(1);
    // Start, sync and wrap collapse into one restart, so a sync on the wrap edge ticks once.
    assign reload  = (state == CH_IDLE) || sync_i || (cnt == div_r);

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state  <= CH_IDLE;
            cnt    <= '0;
            div_r  <= '0;
            high_r <= '0;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
        end else if (!en_i) begin
            state  <= CH_IDLE;
            cnt    <= '0;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
        end else if (reload) begin
            state  <= CH_RUN;
            div_r  <= div_i;
            high_r <= h;
            cnt    <= '0;
            out_r  <= (h != '0);
            tick_r <= 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            out_r  <= (cnt_nxt < high_r);
            tick_r <= 1'b0;
        end
    end

    assign clk_out = out_r;
    assign tick_o  = tick_r;

endmodule

// File: rtl/clock_divider_multi.sv
// N_CH independent programmable clock dividers sharing a phase-align sync strobe.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  nrst,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic [N_CH*DIV_W-1:0] high_i,
    input  logic [N_CH-1:0]       half_i,
    input  logic                  sync_i,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick_o
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clkdiv_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_in (clk_in),
            .nrst   (nrst),
            .en_i   (en_i[c]),
            .div_i  (div_i[c*DIV_W +: DIV_W]),
            .high_i (high_i[c*DIV_W +: DIV_W]),
            .half_i (half_i[c]),
            .sync_i (sync_i),
            .clk_out(clk_out[c]),
            .tick_o (tick_o[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: vector table, directed corner sequences, random vs model.
module tb_clock_divider_multi;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned DIV_W = 8;

    logic                  clk_in;
    logic                  nrst;
    logic [N_CH-1:0]       en_i;
    logic [N_CH*DIV_W-1:0] div_i;
    logic [N_CH*DIV_W-1:0] high_i;
    logic [N_CH-1:0]       half_i;
    logic                  sync_i;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick_o;

    int checks;
    int errors;

    clock_divider_multi #(
        .N_CH (N_CH),
        .DIV_W(DIV_W)
    ) dut (
        .clk_in (clk_in),
        .nrst   (nrst),
        .en_i   (en_i),
        .div_i  (div_i),
        .high_i (high_i),
        .half_i (half_i),
        .sync_i (sync_i),
        .clk_out(clk_out),
        .tick_o (tick_o)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  div;
        logic [7:0]  high;
        logic        half;
        logic [15:0] exp_out;
        logic [15:0] exp_tick;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input int d, input int h, input logic hf);
        div_i[c*DIV_W +: DIV_W]  = DIV_W'(d);
        high_i[c*DIV_W +: DIV_W] = DIV_W'(h);
        half_i[c]                = hf;
    endtask

    // Reference model: absolute period start time plus latched period/high lengths per channel.
    int  m_start[N_CH];
    int  m_per[N_CH];
    int  m_hi[N_CH];
    bit  m_run[N_CH];
    int  cyc;

    initial begin
        logic [N_CH-1:0] exp_o;
        logic [N_CH-1:0] exp_t;
        logic [1:0]      t4_o[7];
        logic [1:0]      t4_t[7];

        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        en_i   = '0;
        div_i  = '0;
        high_i = '0;
        half_i = '0;
        sync_i = 1'b0;

        vecs[0] = '{div: 8'd3, high: 8'd0, half: 1'b1, exp_out: 16'h3333, exp_tick: 16'h1111};
        vecs[1] = '{div: 8'd4, high: 8'd0, half: 1'b1, exp_out: 16'h8C63, exp_tick: 16'h8421};
        vecs[2] = '{div: 8'd4, high: 8'd0, half: 1'b0, exp_out: 16'h0000, exp_tick: 16'h8421};
        vecs[3] = '{div: 8'd4, high: 8'd9, half: 1'b0, exp_out: 16'hFFFF, exp_tick: 16'h8421};
        vecs[4] = '{div: 8'd0, high: 8'd1, half: 1'b0, exp_out: 16'hFFFF, exp_tick: 16'hFFFF};
        vecs[5] = '{div: 8'd2, high: 8'd1, half: 1'b0, exp_out: 16'h9249, exp_tick: 16'h9249};
        vecs[6] = '{div: 8'd0, high: 8'd0, half: 1'b1, exp_out: 16'h0000, exp_tick: 16'hFFFF};

        #12;
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick", 32'(tick_o), 32'h0);
        nrst = 1'b1;
        step();
        check("idle_clk_out", 32'(clk_out), 32'h0);

        // Vector table on channel 0, fresh period for each record.
        for (int v = 0; v < 7; v++) begin
            en_i[0] = 1'b0;
            set_ch(0, int'(vecs[v].div), int'(vecs[v].high), vecs[v].half);
            step();
            check("tbl_disabled", 32'(clk_out[0]), 32'h0);
            en_i[0] = 1'b1;
            for (int i = 0; i < 16; i++) begin
                step();
                check($sformatf("tbl%0d_out%0d", v, i), 32'(clk_out[0]), 32'(vecs[v].exp_out[i]));
                check($sformatf("tbl%0d_tick%0d", v, i), 32'(tick_o[0]), 32'(vecs[v].exp_tick[i]));
            end
        end

        // Mid-period divisor change only lands at the next wrap.
        en_i = '0;
        step();
        set_ch(0, 3, 0, 1'b1);
        en_i[0] = 1'b1;
        step();
        step();
        set_ch(0, 7, 0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            step();
            check($sformatf("reload_out%0d", k), 32'(clk_out[0]), 32'((k >= 2 && k <= 5) || k == 10));
            check($sformatf("reload_tick%0d", k), 32'(tick_o[0]), 32'(k == 2 || k == 10));
        end

        // Sync aligns two free-running channels with different periods.
        en_i = '0;
        step();
        set_ch(0, 3, 0, 1'b1);
        set_ch(1, 5, 0, 1'b1);
        en_i = 4'b0001;
        step();
        step();
        en_i = 4'b0011;
        step();
        step();
        step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        t4_o = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
        t4_t = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            check($sformatf("sync_out%0d", k), 32'(clk_out[1:0]), 32'(t4_o[k]));
            check($sformatf("sync_tick%0d", k), 32'(tick_o[1:0]), 32'(t4_t[k]));
        end

        // Maximum divisor with auto duty: 128 high, 128 low.
        en_i = '0;
        step();
        set_ch(2, 255, 0, 1'b1);
        en_i[2] = 1'b1;
        for (int i = 0; i < 512; i++) begin
            step();
            check("div255_out", 32'(clk_out[2]), 32'((i % 256) < 128));
            check("div255_tick", 32'(tick_o[2]), 32'((i % 256) == 0));
        end

        // Disable mid-period, re-enable, then asynchronous reset.
        en_i = '0;
        step();
        set_ch(0, 7, 0, 1'b1);
        en_i[0] = 1'b1;
        step();
        step();
        step();
        check("dis_pre_out", 32'(clk_out[0]), 32'h1);
        en_i[0] = 1'b0;
        step();
        check("dis_out", 32'(clk_out[0]), 32'h0);
        check("dis_tick", 32'(tick_o[0]), 32'h0);
        en_i[0] = 1'b1;
        step();
        check("reen_tick", 32'(tick_o[0]), 32'h1);
        check("reen_out", 32'(clk_out[0]), 32'h1);
        step();
        nrst = 1'b0;
        #1;
        check("arst_out", 32'(clk_out), 32'h0);
        check("arst_tick", 32'(tick_o), 32'h0);
        #1;
        nrst = 1'b1;
        step();
        check("post_rst_tick", 32'(tick_o[0]), 32'h1);
        check("post_rst_out", 32'(clk_out[0]), 32'h1);

        // Randomised traffic against the reference model.
        en_i = '0;
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            m_run[c] = 1'b0;
            set_ch(c, int'($urandom_range(0, 9)), int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));
        end
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 19) == 0) en_i[c] = ~en_i[c];
                if ($urandom_range(0, 15) == 0)
                    set_ch(c, int'($urandom_range(0, 9)), int'($urandom_range(0, 11)),
                           1'($urandom_range(0, 1)));
            end
            sync_i = ($urandom_range(0, 24) == 0);
            step();
            cyc++;
            for (int c = 0; c < N_CH; c++) begin
                int d;
                int h;
                int ph;
                d = int'(div_i[c*DIV_W +: DIV_W]);
                h = half_i[c] ? (d + 1) / 2 : int'(high_i[c*DIV_W +: DIV_W]);
                if (!en_i[c]) begin
                    m_run[c] = 1'b0;
                    exp_o[c] = 1'b0;
                    exp_t[c] = 1'b0;
                end else begin
                    ph = cyc - m_start[c];
                    if (!m_run[c] || sync_i || ph == m_per[c]) begin
                        m_run[c]   = 1'b1;
                        m_start[c] = cyc;
                        m_per[c]   = d + 1;
                        m_hi[c]    = h;
                        ph         = 0;
                    end
                    exp_o[c] = (ph < m_hi[c]);
                    exp_t[c] = (ph == 0);
                end
            end
            check("rand_out", 32'(clk_out), 32'(exp_o));
            check("rand_tick", 32'(tick_o), 32'(exp_t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
